seg7_scan: RTL

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_scan_if.sv | 27 ++
 rtl/bcd_to_seg7.sv | 28 ++
 rtl/seg7_scan.sv | 108 ++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef logic [1:0] idx_t;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
    } frame_t;

endpackage

// File: rtl/seg7_scan_if.sv
// Display bus: BCD digits and decimal points in, scanned drive out.
// master drives the digit data, slave is the scanner.
interface seg7_scan_if;

    logic [15:0] DIGITS;
    logic [3:0]  DP_IN;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  AN;

    modport master (
        output DIGITS,
        output DP_IN,
        input  SEG,
        input  DP,
        input  AN
    );

    modport slave (
        input  DIGITS,
        input  DP_IN,
        output SEG,
        output DP,
        output AN
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder.
// Nibbles A-F render as a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Map each nibble to its segment pattern.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner with frame snapshot.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_HZ  = 125000000,
    parameter int SCAN_HZ = 1000
)(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] DIGITS,
    input  logic [3:0]  DP_IN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  AN
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] r_div;
    idx_t             r_idx;
    frame_t           r_frame;
    logic             r_upd;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic [3:0]       r_an;

    logic             w_tick;
    logic [3:0]       w_nib;
    logic [6:0]       w_seg;
    logic             w_dp;
    logic [3:0]       w_an;
    logic             w_blank;

    assign w_tick = (r_div == DIV_LAST);
    assign w_nib  = r_frame.digits[{r_idx, 2'b00} +: 4];
    assign w_dp   = r_frame.dp[r_idx];
    assign w_an   = ~(4'b0001 << r_idx);

`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0] w_upper;
    assign w_upper = r_frame.digits >> {r_idx, 2'b00};
    // Digit 0 always shows; a DP request keeps a zero digit lit.
    assign w_blank = (r_idx != 2'd0) && (w_upper == 16'h0) && !w_dp;
`else
    assign w_blank = 1'b0;
`endif

    bcd_to_seg7 u_dec (
        .i_bcd (w_nib),
        .o_seg (w_seg)
    );

    // Free-running scan divider, one-cycle tick at the last count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Advance digit index on tick; snapshot inputs when wrapping to 0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_idx   <= 2'd3;
            r_frame <= '0;
            r_upd   <= 1'b0;
        end else begin
            r_upd <= w_tick;
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_frame.digits <= DIGITS;
                    r_frame.dp     <= DP_IN;
                end
            end
        end
    end

    // Register the drive for the new digit the cycle after each tick.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b0;
            r_an  <= 4'hF;
        end else if (r_upd) begin
            if (w_blank) begin
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b0;
                r_an  <= 4'hF;
            end else begin
                r_seg <= w_seg;
                r_dp  <= w_dp;
                r_an  <= w_an;
            end
        end
    end

    assign SEG = r_seg;
    assign DP  = r_dp;
    assign AN  = r_an;

endmodule
